// File: rtl/mr_ifq.sv
// Instruction queue between ifetch and ID: registered valid/ready FIFO, flushed on redirect.
// if_ready depends only on registered occupancy and rst, never on id_ready.
module mr_ifq #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned IMAXLEN = 32,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [IMAXLEN-1:0]           if_inst,
  input  logic [XLEN-1:0]              if_pc,
  input  logic                         if_valid,
  output logic                         if_ready,
  output logic [IMAXLEN-1:0]           id_inst,
  output logic [XLEN-1:0]              id_pc,
  output logic                         id_valid,
  input  logic                         id_ready,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [IMAXLEN-1:0] inst_mem_q [DEPTH];
  logic [XLEN-1:0]    pc_mem_q   [DEPTH];

  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               id_valid_q, id_valid_d;
  logic [IMAXLEN-1:0] id_inst_q, id_inst_d;
  logic [XLEN-1:0]    id_pc_q, id_pc_d;

  logic full_c;
  logic enq_c;
  logic deq_c;
  logic head_wr_c;

  assign full_c   = (count_q == CW'(DEPTH));
  assign if_ready = !full_c && !rst;
  assign enq_c    = if_valid && if_ready;
  assign deq_c    = id_valid_q && id_ready;

  assign id_valid = id_valid_q;
  assign id_inst  = id_inst_q;
  assign id_pc    = id_pc_q;
  assign count    = count_q;

  // Next pointers/occupancy, then preload the head register for the next cycle.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    id_valid_d = 1'b0;
    id_inst_d  = id_inst_q;
    id_pc_d    = id_pc_q;
    head_wr_c  = 1'b0;

    if (enq_c) wr_ptr_d = wr_ptr_q + PW'(1);
    if (deq_c) rd_ptr_d = rd_ptr_q + PW'(1);

    case ({enq_c, deq_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Flush drops everything, including a same-cycle enqueue.
    if (flush) begin
      count_d  = '0;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = wr_ptr_q;
    end

    id_valid_d = (count_d != '0);
    // Slot being written this edge is the new head only when it becomes the sole entry.
    head_wr_c  = enq_c && !flush && (wr_ptr_q == rd_ptr_d);

    if (id_valid_d) begin
      if (head_wr_c) begin
        id_inst_d = if_inst;
        id_pc_d   = if_pc;
      end else begin
        id_inst_d = inst_mem_q[rd_ptr_d];
        id_pc_d   = pc_mem_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      id_valid_q <= 1'b0;
      id_inst_q  <= '0;
      id_pc_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      id_valid_q <= id_valid_d;
      id_inst_q  <= id_inst_d;
      id_pc_q    <= id_pc_d;
    end
  end

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (enq_c && !flush) begin
      inst_mem_q[wr_ptr_q] <= if_inst;
      pc_mem_q[wr_ptr_q]   <= if_pc;
    end
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    (if_valid && if_ready) |-> (count_q != CW'(DEPTH)));
  a_no_underflow : assert property (@(posedge clk) disable iff (rst)
    (id_valid && id_ready) |-> (count_q != '0));

endmodule

// File: tb/tb_mr_ifq.sv
// Bench for mr_ifq: directed vector table for the corner sequences, then a queue-model random run.
module tb_mr_ifq;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] KEY   = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        id_valid;
  logic        id_ready;
  logic        flush;
  logic [2:0]  count;

  int n_tests = 0;
  int n_fail  = 0;

  mr_ifq #(.XLEN(32), .IMAXLEN(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .if_inst(if_inst), .if_pc(if_pc), .if_valid(if_valid), .if_ready(if_ready),
    .id_inst(id_inst), .id_pc(id_pc), .id_valid(id_valid), .id_ready(id_ready),
    .flush(flush), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        iv;
    logic [31:0] pc;
    logic        ir;
    logic        fl;
    int          cnt;
    logic        idv;
    logic        ifr;
    int          chk;   // 0: head not checked, 1: head pc/inst, 2: head all-zero
    logic [31:0] hpc;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  vec_t vecs[$];
  ent_t mq[$];

  function automatic vec_t mk(input logic r, input logic iv, input logic [31:0] pc,
                              input logic ir, input logic fl, input int cnt,
                              input logic idv, input logic ifr, input int chk,
                              input logic [31:0] hpc);
    vec_t v;
    v.rst = r; v.iv = iv; v.pc = pc; v.ir = ir; v.fl = fl;
    v.cnt = cnt; v.idv = idv; v.ifr = ifr; v.chk = chk; v.hpc = hpc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // One model-checked cycle: queue semantics decide what the DUT must show afterwards.
  task automatic mstep(input logic r, input logic iv, input logic [31:0] pc,
                       input logic [31:0] inst, input logic ir, input logic fl,
                       output logic accepted);
    int  sz;
    logic enq, deq;
    ent_t e;
    rst = r; if_valid = iv; if_pc = pc; if_inst = inst; id_ready = ir; flush = fl;
    sz  = mq.size();
    enq = iv && !r && (sz < DEPTH);
    deq = ir && !r && (sz != 0);
    @(posedge clk);
    if (r) begin
      mq.delete();
    end else begin
      if (deq) void'(mq.pop_front());
      if (fl) mq.delete();
      else if (enq) begin
        e.pc = pc; e.inst = inst;
        mq.push_back(e);
      end
    end
    accepted = enq && !fl;
    #1;
    chk("m_count", 64'(count), 64'(mq.size()));
    chk("m_id_valid", 64'(id_valid), 64'(mq.size() != 0));
    chk("m_if_ready", 64'(if_ready), 64'(!rst && (mq.size() < DEPTH)));
    if (mq.size() != 0) begin
      chk("m_id_pc", 64'(id_pc), 64'(mq[0].pc));
      chk("m_id_inst", 64'(id_inst), 64'(mq[0].inst));
    end
  endtask

  initial begin
    logic        acc;
    logic [31:0] npc;
    vec_t        v;

    rst = 1'b1; if_valid = 1'b0; if_pc = '0; if_inst = '0; id_ready = 1'b0; flush = 1'b0;

    // Reset, 5 idle cycles
    vecs.push_back(mk(1, 0, 32'h0,   0, 0, 0, 0, 0, 2, 32'h0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 0, 32'h0, 0, 0, 0, 0, 1, 2, 32'h0));
    // Streaming with ID always ready
    vecs.push_back(mk(0, 1, 32'h0,   1, 0, 1, 1, 1, 1, 32'h0));
    vecs.push_back(mk(0, 1, 32'h4,   1, 0, 1, 1, 1, 1, 32'h4));
    vecs.push_back(mk(0, 1, 32'h8,   1, 0, 1, 1, 1, 1, 32'h8));
    vecs.push_back(mk(0, 1, 32'hC,   1, 0, 1, 1, 1, 1, 32'hC));
    vecs.push_back(mk(0, 0, 32'h0,   1, 0, 0, 0, 1, 0, 32'h0));
    // Fill and backpressure
    vecs.push_back(mk(0, 1, 32'h0,   0, 0, 1, 1, 1, 1, 32'h0));
    vecs.push_back(mk(0, 1, 32'h4,   0, 0, 2, 1, 1, 1, 32'h0));
    vecs.push_back(mk(0, 1, 32'h8,   0, 0, 3, 1, 1, 1, 32'h0));
    vecs.push_back(mk(0, 1, 32'hC,   0, 0, 4, 1, 0, 1, 32'h0));
    vecs.push_back(mk(0, 1, 32'h10,  0, 0, 4, 1, 0, 1, 32'h0));
    vecs.push_back(mk(0, 1, 32'h10,  1, 0, 3, 1, 1, 1, 32'h4));
    vecs.push_back(mk(0, 1, 32'h10,  0, 0, 4, 1, 0, 1, 32'h4));
    vecs.push_back(mk(0, 0, 32'h0,   1, 0, 3, 1, 1, 1, 32'h8));
    vecs.push_back(mk(0, 0, 32'h0,   1, 0, 2, 1, 1, 1, 32'hC));
    vecs.push_back(mk(0, 0, 32'h0,   1, 0, 1, 1, 1, 1, 32'h10));
    vecs.push_back(mk(0, 0, 32'h0,   1, 0, 0, 0, 1, 0, 32'h0));
    // Flush at count 3 with a push in the same cycle
    vecs.push_back(mk(0, 1, 32'h20,  0, 0, 1, 1, 1, 1, 32'h20));
    vecs.push_back(mk(0, 1, 32'h24,  0, 0, 2, 1, 1, 1, 32'h20));
    vecs.push_back(mk(0, 1, 32'h28,  0, 0, 3, 1, 1, 1, 32'h20));
    vecs.push_back(mk(0, 1, 32'h2C,  0, 1, 0, 0, 1, 0, 32'h0));
    vecs.push_back(mk(0, 1, 32'h100, 0, 0, 1, 1, 1, 1, 32'h100));
    vecs.push_back(mk(0, 0, 32'h0,   1, 0, 0, 0, 1, 0, 32'h0));
    // Reset mid-operation
    vecs.push_back(mk(0, 1, 32'h40,  0, 0, 1, 1, 1, 1, 32'h40));
    vecs.push_back(mk(0, 1, 32'h44,  0, 0, 2, 1, 1, 1, 32'h40));
    vecs.push_back(mk(0, 1, 32'h48,  0, 0, 3, 1, 1, 1, 32'h40));
    vecs.push_back(mk(1, 1, 32'h4C,  1, 0, 0, 0, 0, 2, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,   1, 0, 0, 0, 1, 2, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,   1, 0, 0, 0, 1, 2, 32'h0));

    foreach (vecs[i]) begin
      v = vecs[i];
      rst = v.rst; if_valid = v.iv; if_pc = v.pc; if_inst = v.pc ^ KEY;
      id_ready = v.ir; flush = v.fl;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_count", i), 64'(count), 64'(v.cnt));
      chk($sformatf("v%0d_id_valid", i), 64'(id_valid), 64'(v.idv));
      chk($sformatf("v%0d_if_ready", i), 64'(if_ready), 64'(v.ifr));
      if (v.chk == 1) begin
        chk($sformatf("v%0d_id_pc", i), 64'(id_pc), 64'(v.hpc));
        chk($sformatf("v%0d_id_inst", i), 64'(id_inst), 64'(v.hpc ^ KEY));
      end else if (v.chk == 2) begin
        chk($sformatf("v%0d_id_pc0", i), 64'(id_pc), 64'(0));
        chk($sformatf("v%0d_id_inst0", i), 64'(id_inst), 64'(0));
      end
    end

    // Wrap-around: steady count of 2 with push and pop every cycle
    mstep(1, 0, 32'h0, 32'h0, 0, 0, acc);
    npc = 32'h200;
    for (int i = 0; i < 2; i++) begin
      mstep(0, 1, npc, npc ^ KEY, 0, 0, acc);
      if (acc) npc += 32'h4;
    end
    for (int i = 0; i < 10; i++) begin
      mstep(0, 1, npc, npc ^ KEY, 1, 0, acc);
      if (acc) npc += 32'h4;
      chk("wrap_count", 64'(count), 64'(2));
    end
    for (int i = 0; i < 3; i++) mstep(0, 0, 32'h0, 32'h0, 1, 0, acc);

    // Random traffic including flush and occasional reset
    for (int i = 0; i < 600; i++) begin
      logic [31:0] ri;
      ri = $urandom;
      mstep(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), npc, ri,
            ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0), acc);
      if (acc) npc += 32'h4;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
